// File: rtl/detector_share_arbiter.sv
// Round-robin arbiter that lends one serial counter/detector core to N_REQ
// requesters, sequences its start/ready handshake and recovers a hung core
// with an ack timeout and a run timeout.
module detector_share_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ACK_TO = 8,
  parameter int RUN_TO = 255
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] ser_in,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             err,
  output logic [N_REQ-1:0] ser_out,
  output logic             det_start,
  output logic             det_rst,
  output logic             det_serialin,
  input  logic             det_ready,
  input  logic             det_serialout
);

  localparam int CW = $clog2(RUN_TO + 1);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Timeouts fire on the cycle the counter would reach its limit, so the
  // core gets exactly ACK_TO (or RUN_TO) cycles before being aborted.
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] ACK_LIM = CW'(ACK_TO - 1);
  localparam logic [CW-1:0] RUN_LIM = CW'(RUN_TO - 1);
  localparam logic [PW-1:0] LAST    = PW'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACK,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     owner, owner_n;
  logic [PW-1:0]     rr_ptr, rr_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [N_REQ-1:0]  grant_n, done_n;
  logic              err_n, start_n, drst_n;
  logic              pick_valid;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     owner_inc;
  logic [CW-1:0]     cnt_inc;

  assign owner_inc = (owner == LAST) ? '0 : owner + 1'b1;
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // Find the first requesting channel at or after rr_ptr, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_valid && req[(int'(rr_ptr) + i) % N_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  // Next-state logic; pulse outputs are computed here and registered below.
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n    = rr_ptr;
    cnt_n   = cnt;
    grant_n = grant;
    done_n  = '0;
    err_n   = 1'b0;
    start_n = 1'b0;
    drst_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          owner_n = pick_idx;
          grant_n = N_REQ'(1) << pick_idx;
          state_n = S_START;
        end
      end
      S_START: begin
        start_n = 1'b1;
        cnt_n   = '0;
        state_n = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!det_ready) begin
          cnt_n   = '0;
          state_n = S_RUN;
        end else if (cnt >= ACK_LIM) begin
          err_n   = 1'b1;
          drst_n  = 1'b1;
          state_n = S_ABORT;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_RUN: begin
        if (det_ready) begin
          done_n  = grant;
          state_n = S_DONE;
        end else if (cnt >= RUN_LIM) begin
          err_n   = 1'b1;
          drst_n  = 1'b1;
          state_n = S_ABORT;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_DONE, S_ABORT: begin
        grant_n = '0;
        rr_n    = owner_inc;
        state_n = S_IDLE;
      end
      default: begin
        grant_n = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset parks everything idle.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      grant     <= '0;
      done      <= '0;
      err       <= 1'b0;
      det_start <= 1'b0;
      det_rst   <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      rr_ptr    <= rr_n;
      cnt       <= cnt_n;
      grant     <= grant_n;
      done      <= done_n;
      err       <= err_n;
      det_start <= start_n;
      det_rst   <= drst_n;
    end
  end

  assign ser_out      = grant & {N_REQ{det_serialout}};
  assign det_serialin = |(grant & ser_in);

endmodule

// File: tb/tb_detector_share_arbiter.sv
// Directed bench for detector_share_arbiter: table of full runs for the
// round-robin order, plus hand sequences for timeouts, reset and serial path.
module tb_detector_share_arbiter;

  logic       clock;
  logic       rst;
  logic [3:0] req;
  logic [3:0] ser_in;
  logic [3:0] grant;
  logic [3:0] done;
  logic       err;
  logic [3:0] ser_out;
  logic       det_start;
  logic       det_rst;
  logic       det_serialin;
  logic       det_ready;
  logic       det_serialout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    int         ack_delay;
    int         run_len;
  } vec_t;

  vec_t vecs [10];

  detector_share_arbiter #(.N_REQ(4), .ACK_TO(8), .RUN_TO(255)) dut (
    .clock         (clock),
    .rst           (rst),
    .req           (req),
    .ser_in        (ser_in),
    .grant         (grant),
    .done          (done),
    .err           (err),
    .ser_out       (ser_out),
    .det_start     (det_start),
    .det_rst       (det_rst),
    .det_serialin  (det_serialin),
    .det_ready     (det_ready),
    .det_serialout (det_serialout)
  );

  initial clock = 1'b0;
  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and sample 1 unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    check_output("grant_onehot0", 32'($onehot0(grant)), 1);
    check_output("done_err_excl", 32'((|done) && err), 0);
  endtask

  // One complete normal run starting from an idle arbiter with req applied.
  task automatic apply_stimulus(input logic [3:0] exp_g, input int ack_d, input int run_n);
    tick();
    check_output("grant", grant, exp_g);
    check_output("det_start_early", det_start, 0);
    tick();
    check_output("det_start", det_start, 1);
    check_output("grant_hold", grant, exp_g);
    for (int k = 0; k < ack_d; k++) begin
      tick();
      check_output("det_start_width", det_start, 0);
    end
    det_ready = 1'b0;
    tick();
    for (int k = 0; k < run_n; k++) begin
      ser_in        = 4'(k * 5 + 3);
      det_serialout = k[0];
      #1;
      check_output("det_serialin", det_serialin, |(exp_g & ser_in));
      check_output("ser_out", ser_out, exp_g & {4{det_serialout}});
      check_output("no_done_in_run", done, 0);
      tick();
    end
    det_ready = 1'b1;
    tick();
    check_output("done", done, exp_g);
    check_output("err_quiet", err, 0);
    tick();
    check_output("done_clear", done, 0);
    check_output("grant_clear", grant, 0);
  endtask

  initial begin
    vecs[0] = '{4'b0100, 4'b0100, 1, 20};
    vecs[1] = '{4'b1111, 4'b1000, 1, 7};
    vecs[2] = '{4'b1111, 4'b0001, 1, 7};
    vecs[3] = '{4'b1111, 4'b0010, 1, 7};
    vecs[4] = '{4'b1111, 4'b0100, 1, 7};
    vecs[5] = '{4'b1111, 4'b1000, 1, 7};
    vecs[6] = '{4'b0110, 4'b0010, 0, 3};
    vecs[7] = '{4'b0110, 4'b0100, 2, 4};
    vecs[8] = '{4'b0011, 4'b0001, 0, 1};
    vecs[9] = '{4'b0001, 4'b0001, 3, 5};

    rst           = 1'b1;
    req           = '0;
    ser_in        = '0;
    det_ready     = 1'b1;
    det_serialout = 1'b0;
    #3;
    check_output("rst_grant", grant, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    check_output("rst_det_start", det_start, 0);
    check_output("rst_det_rst", det_rst, 0);
    @(posedge clock);
    #1;
    rst = 1'b0;

    // Round-robin order across full normal runs.
    for (int v = 0; v < 10; v++) begin
      req = vecs[v].req;
      apply_stimulus(vecs[v].exp_grant, vecs[v].ack_delay, vecs[v].run_len);
    end

    // Core never acknowledges: ack timeout 8 cycles after det_start.
    req = 4'b0011;
    tick();
    check_output("ack_to_grant", grant, 4'b0010);
    tick();
    check_output("ack_to_start", det_start, 1);
    for (int k = 1; k < 8; k++) begin
      tick();
      check_output("ack_to_early_err", err, 0);
    end
    tick();
    check_output("ack_to_err", err, 1);
    check_output("ack_to_det_rst", det_rst, 1);
    check_output("ack_to_no_done", done, 0);
    tick();
    check_output("ack_to_err_clear", err, 0);
    check_output("ack_to_grant_clear", grant, 0);

    // Next requester served; core never finishes: run timeout after 255 cycles.
    tick();
    check_output("run_to_grant", grant, 4'b0001);
    tick();
    check_output("run_to_start", det_start, 1);
    det_ready = 1'b0;
    tick();
    for (int k = 1; k < 255; k++) begin
      tick();
      check_output("run_to_early_err", err, 0);
      check_output("run_to_no_done", done, 0);
    end
    tick();
    check_output("run_to_err", err, 1);
    check_output("run_to_det_rst", det_rst, 1);
    check_output("run_to_done", done, 0);
    det_ready = 1'b1;
    req       = '0;
    tick();
    check_output("run_to_grant_clear", grant, 0);
    tick();
    check_output("run_to_idle", grant, 0);

    // Async reset in the middle of a run.
    req = 4'b0010;
    tick();
    check_output("rst_run_grant", grant, 4'b0010);
    tick();
    check_output("rst_run_start", det_start, 1);
    det_ready = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    rst       = 1'b1;
    det_ready = 1'b1;
    #1;
    check_output("rst_mid_grant", grant, 0);
    check_output("rst_mid_start", det_start, 0);
    check_output("rst_mid_done", done, 0);
    check_output("rst_mid_err", err, 0);
    req = 4'b0011;
    #1;
    rst = 1'b0;
    tick();
    check_output("rst_rr_from_zero", grant, 4'b0001);
    tick();
    check_output("rst_fresh_start", det_start, 1);

    // Owner drops req mid-run; serial pattern 1,0,0,1 must pass through.
    det_ready = 1'b0;
    req       = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] pat;
      pat    = 4'b1001;
      ser_in = pat[3 - k] ? 4'b0001 : 4'b1110;
      #1;
      check_output("serial_pattern", det_serialin, pat[3 - k]);
      tick();
    end
    det_ready = 1'b1;
    tick();
    check_output("drop_req_done", done, 4'b0001);
    tick();
    check_output("drop_req_grant_clear", grant, 0);
    tick();
    check_output("drop_req_stay_idle", grant, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
